char_line_renderer: RTL and testbench

CHAR_LINE_RENDERER -- requirements
Module: char_line_renderer

---
 rtl/vga_text_pkg.sv | 20 ++
 rtl/glyph_shifter.sv | 28 ++
 rtl/char_line_renderer.sv | 155 +++++++++++++++
 tb/tb_char_line_renderer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode video path: cell geometry, renderer
// state encoding and the glyph ROM address helper.
package vga_text_pkg;

  localparam int unsigned CELL_W     = 6;
  localparam int unsigned CELL_H     = 8;
  localparam int unsigned GLYPH_ROWS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } render_state_t;

  // code*7 + row built as (code<<3) - code + row, so no multiplier is needed.
  function automatic logic [10:0] rom_addr(input logic [7:0] code, input logic [2:0] row);
    return ({code, 3'b000} - {3'b000, code}) + {8'b0000_0000, row};
  endfunction

endpackage

// File: rtl/glyph_shifter.sv
// One character cell wide load/shift register; MSB is the next pixel out.
module glyph_shifter
  import vga_text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CELL_W-1:0] load_data,
  input  logic              pixel_en,
  output logic              msb
);

  logic [CELL_W-1:0] sr;

  // Load has priority; otherwise shift left only on pixel clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (pixel_en) begin
      sr <= {sr[CELL_W-2:0], 1'b0};
    end
  end

  assign msb = sr[CELL_W-1];

endmodule

// File: rtl/char_line_renderer.sv
// Renders one scan line of a text buffer as a serial pixel stream: per
// character a text RAM read, then a glyph ROM read, then 6 pixels shifted out
// while the next character is prefetched into a one-entry glyph buffer.
// Optional feature: define CURSOR_EN to add cursor_on/cursor_col and invert
// the cell at cursor_col.
module char_line_renderer
  import vga_text_pkg::*;
#(
  parameter int COLS    = 100,
  parameter int TEXT_AW = 12
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [TEXT_AW-1:0] line_base,
  input  logic [2:0]         scan_row,
  input  logic               pixel_en,
  output logic [TEXT_AW-1:0] text_addr,
  output logic               text_ce,
  input  logic [7:0]         text_data,
`ifdef CURSOR_EN
  input  logic               cursor_on,
  input  logic [7:0]         cursor_col,
`endif
  output logic [10:0]        rom_ad,
  output logic               rom_ce,
  input  logic [4:0]         rom_dout,
  output logic               pixel,
  output logic               pixel_valid,
  output logic               line_done
);

  localparam logic [8:0] NCOLS = 9'(COLS);

  render_state_t state;
  logic [2:0]    row_q;
  // Fetch pipeline markers: text read, text data, ROM read, ROM data.
  logic          f0, f1, f2, f3;
  logic [8:0]    fcnt, lcnt;
  logic [2:0]    px_left;
  logic [4:0]    glyph_buf;
  logic          buf_valid;
  logic          last_q;
  logic          blank_row, busy, shift_now, load_now, issue_now, last_px;
  logic [CELL_W-1:0] load_data;
  logic          sh_msb;

  assign blank_row = (row_q >= 3'(GLYPH_ROWS));

  // Per-cycle decisions: emit a pixel, reload the shifter, start a prefetch.
  always_comb begin
    busy      = f0 | f1 | f2 | f3;
    shift_now = (state != IDLE) && pixel_en && (px_left != 3'd0);
    // Reloading on the last shift of a cell keeps the stream gap-free.
    load_now  = (state != IDLE) && buf_valid &&
                ((px_left == 3'd0) || (shift_now && (px_left == 3'd1)));
    issue_now = (state != IDLE) && !busy && (!buf_valid || load_now) && (fcnt != NCOLS);
    last_px   = shift_now && (px_left == 3'd1) && (lcnt == NCOLS);
    load_data = {glyph_buf, 1'b0};
`ifdef CURSOR_EN
    if (cursor_on && (lcnt == {1'b0, cursor_col})) begin
      load_data = ~load_data;
    end
`endif
  end

  // Line FSM, fetch pipeline, glyph buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row_q       <= '0;
      f0          <= 1'b0;
      f1          <= 1'b0;
      f2          <= 1'b0;
      f3          <= 1'b0;
      fcnt        <= '0;
      lcnt        <= '0;
      px_left     <= '0;
      glyph_buf   <= '0;
      buf_valid   <= 1'b0;
      last_q      <= 1'b0;
      text_addr   <= '0;
      text_ce     <= 1'b0;
      rom_ad      <= '0;
      rom_ce      <= 1'b0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
    end else if (line_start) begin
      // Restart discards any in-flight fetch of the previous line.
      state       <= PRIME;
      row_q       <= scan_row;
      text_addr   <= line_base;
      text_ce     <= (scan_row < 3'(GLYPH_ROWS));
      f0          <= 1'b1;
      f1          <= 1'b0;
      f2          <= 1'b0;
      f3          <= 1'b0;
      fcnt        <= 9'd1;
      lcnt        <= '0;
      px_left     <= '0;
      buf_valid   <= 1'b0;
      last_q      <= 1'b0;
      rom_ce      <= 1'b0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
    end else begin
      f0      <= issue_now;
      f1      <= f0;
      f2      <= f1;
      f3      <= f2;
      text_ce <= issue_now && !blank_row;
      if (issue_now) begin
        text_addr <= text_addr + 1'b1;
        fcnt      <= fcnt + 1'b1;
      end
      rom_ce <= f1 && !blank_row;
      if (f1 && !blank_row) begin
        rom_ad <= rom_addr(text_data, row_q);
      end
      if (load_now) begin
        buf_valid <= 1'b0;
        lcnt      <= lcnt + 1'b1;
        px_left   <= 3'(CELL_W);
      end else if (shift_now) begin
        px_left <= px_left - 1'b1;
      end
      if (f3) begin
        glyph_buf <= blank_row ? 5'b00000 : rom_dout;
        buf_valid <= 1'b1;
      end
      pixel       <= shift_now && sh_msb;
      pixel_valid <= shift_now;
      last_q      <= last_px;
      line_done   <= last_q;
      case (state)
        PRIME:   if (load_now) state <= RUN;
        RUN:     if (last_px)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  glyph_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load_now),
    .load_data (load_data),
    .pixel_en  (pixel_en),
    .msb       (sh_msb)
  );

endmodule

// File: tb/tb_char_line_renderer.sv
// Scoreboard bench for char_line_renderer with COLS=3, TEXT_AW=4 and
// behavioural text RAM / glyph ROM models.
module tb_char_line_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [3:0]  line_base = '0;
  logic [2:0]  scan_row = '0;
  logic        pixel_en = 1'b1;
  logic [3:0]  text_addr;
  logic        text_ce;
  logic [7:0]  text_data = '0;
  logic [10:0] rom_ad;
  logic        rom_ce;
  logic [4:0]  rom_dout = '0;
  logic        pixel, pixel_valid, line_done;
`ifdef CURSOR_EN
  logic        cursor_on = 1'b0;
  logic [7:0]  cursor_col = '0;
`endif

  char_line_renderer #(.COLS(3), .TEXT_AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .line_base   (line_base),
    .scan_row    (scan_row),
    .pixel_en    (pixel_en),
    .text_addr   (text_addr),
    .text_ce     (text_ce),
    .text_data   (text_data),
`ifdef CURSOR_EN
    .cursor_on   (cursor_on),
    .cursor_col  (cursor_col),
`endif
    .rom_ad      (rom_ad),
    .rom_ce      (rom_ce),
    .rom_dout    (rom_dout),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .line_done   (line_done)
  );

  always #5 clk = ~clk;

  logic [7:0] tmem [16];
  logic [4:0] rom  [2048];

  always @(posedge clk) begin
    if (text_ce) text_data <= tmem[text_addr];
    if (rom_ce)  rom_dout  <= rom[rom_ad];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0, first_v = 0, last_v = 0, nvalid = 0, done_cyc = 0;
  int line_dones = 0, ce_hits = 0;
  logic        exp_px [$];
  logic [3:0]  exp_ta [$];
  logic [10:0] exp_ra [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops expected pixels/addresses whenever the DUT presents them.
  always @(negedge clk) begin
    cyc++;
    if (pixel_valid === 1'b1) begin
      if (nvalid == 0) first_v = cyc;
      last_v = cyc;
      nvalid++;
      if (exp_px.size() == 0) begin
        checks++; failures++;
        $display("FAIL pixel_extra got=%0b required=none", pixel);
      end else check("pixel", pixel, exp_px.pop_front());
    end else begin
      check("pixel_blank", pixel, 0);
    end
    if (text_ce === 1'b1) begin
      ce_hits++;
      if (exp_ta.size() == 0) begin
        checks++; failures++;
        $display("FAIL text_ce_extra got=%0h required=none", text_addr);
      end else check("text_addr", text_addr, exp_ta.pop_front());
    end
    if (rom_ce === 1'b1) begin
      ce_hits++;
      if (exp_ra.size() == 0) begin
        checks++; failures++;
        $display("FAIL rom_ce_extra got=%0d required=none", rom_ad);
      end else check("rom_ad", rom_ad, exp_ra.pop_front());
    end
    if (line_done === 1'b1) begin
      line_dones++;
      done_cyc = cyc;
    end
  end

  task automatic flush;
    exp_px.delete();
    exp_ta.delete();
    exp_ra.delete();
    nvalid = 0;
    line_dones = 0;
    ce_hits = 0;
  endtask

  task automatic start_line(input logic [3:0] base, input logic [2:0] row, input logic [17:0] pix,
                            input logic [10:0] ra0, input logic [10:0] ra1, input logic [10:0] ra2);
    flush();
    for (int i = 0; i < 18; i++) exp_px.push_back(pix[17-i]);
    if (row != 3'd7) begin
      exp_ta.push_back(base);
      exp_ta.push_back(base + 4'd1);
      exp_ta.push_back(base + 4'd2);
      exp_ra.push_back(ra0);
      exp_ra.push_back(ra1);
      exp_ra.push_back(ra2);
    end
    line_base  = base;
    scan_row   = row;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic finish_line(input bit toggle, input int span, input string tag);
    int n;
    n = 0;
    while (line_dones == 0 && n < 300) begin
      pixel_en = toggle ? ~pixel_en : 1'b1;
      tick();
      n++;
    end
    pixel_en = 1'b1;
    repeat (6) tick();
    check({tag, "_done_seen"}, 32'(line_dones != 0), 1);
    check({tag, "_nvalid"}, nvalid, 18);
    check({tag, "_span"}, last_v - first_v, span);
    check({tag, "_done_lat"}, done_cyc - last_v, 1);
    check({tag, "_ndone"}, line_dones, 1);
    check({tag, "_queues"}, exp_px.size() + exp_ta.size() + exp_ra.size(), 0);
  endtask

  task automatic wait_valid(input int target, input string tag);
    int n;
    n = 0;
    while (nvalid < target && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, nvalid, target);
  endtask

  // Line A: base F wraps through 0,1; row 2; codes 41,00,FF.
  localparam logic [17:0] PIX_A  = 18'b101100_010010_111110;
  // Line B: base 3; row 6; codes FF,20,41.
  localparam logic [17:0] PIX_B  = 18'b011100_100010_001000;
  localparam logic [17:0] PIX_BC = 18'b011100_011101_001000;

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 5'(i) ^ 5'(i >> 5);
    for (int i = 0; i < 16; i++) tmem[i] = 8'(i * 13 + 7);
    tmem[15] = 8'h41; tmem[0] = 8'h00; tmem[1] = 8'hFF;
    tmem[3]  = 8'hFF; tmem[4] = 8'h20; tmem[5] = 8'h41;
    rom[457]  = 5'b10110; rom[2]   = 5'b01001; rom[1787] = 5'b11111;
    rom[1791] = 5'b01110; rom[230] = 5'b10001; rom[461]  = 5'b00100;

    // Reset wins over a simultaneous line_start.
    line_start = 1'b1;
    repeat (3) tick();
    check("rst_pixel", pixel, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_line_done", line_done, 0);
    check("rst_text_ce", text_ce, 0);
    check("rst_rom_ce", rom_ce, 0);
    check("rst_text_addr", text_addr, 0);
    check("rst_rom_ad", rom_ad, 0);
    line_start = 1'b0;
    reset = 1'b0;
    repeat (2) tick();

    start_line(4'hF, 3'd2, PIX_A, 11'd457, 11'd2, 11'd1787);
    finish_line(1'b0, 17, "A_cont");

    start_line(4'hF, 3'd2, PIX_A, 11'd457, 11'd2, 11'd1787);
    finish_line(1'b1, 34, "A_toggle");

    start_line(4'h3, 3'd6, PIX_B, 11'd1791, 11'd230, 11'd461);
    finish_line(1'b0, 17, "B_cont");

    start_line(4'h0, 3'd7, 18'd0, 11'd0, 11'd0, 11'd0);
    finish_line(1'b0, 17, "row7");
    check("row7_ce_hits", ce_hits, 0);

    // Restart mid-line: the abandoned line must not report line_done.
    start_line(4'hF, 3'd2, PIX_A, 11'd457, 11'd2, 11'd1787);
    wait_valid(3, "abandon");
    start_line(4'h3, 3'd6, PIX_B, 11'd1791, 11'd230, 11'd461);
    finish_line(1'b0, 17, "restart");

    // Reset after the seventh pixel.
    start_line(4'h3, 3'd6, PIX_B, 11'd1791, 11'd230, 11'd461);
    wait_valid(7, "midrst");
    reset = 1'b1;
    tick();
    check("midrst_pixel", pixel, 0);
    check("midrst_pixel_valid", pixel_valid, 0);
    check("midrst_line_done", line_done, 0);
    check("midrst_text_ce", text_ce, 0);
    check("midrst_rom_ce", rom_ce, 0);
    check("midrst_text_addr", text_addr, 0);
    check("midrst_rom_ad", rom_ad, 0);
    flush();
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("midrst_no_done", line_dones, 0);
    check("midrst_no_valid", nvalid, 0);

    start_line(4'hF, 3'd2, PIX_A, 11'd457, 11'd2, 11'd1787);
    finish_line(1'b0, 17, "recover");

`ifdef CURSOR_EN
    cursor_on  = 1'b1;
    cursor_col = 8'd1;
    start_line(4'h3, 3'd6, PIX_BC, 11'd1791, 11'd230, 11'd461);
    finish_line(1'b0, 17, "cursor");
    cursor_on  = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
